// File: rtl/qspi_ram_responder_pkg.sv
// Shared definitions for the serial-RAM responder.
// Opcodes, FSM encoding and helper functions.
package qspi_ram_responder_pkg;

  localparam int ADDRESS_SIZE = 24;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMAND,
    ST_ADDRESS,
    ST_READ_DATA,
    ST_WRITE_DATA,
    ST_IGNORE
  } state_e;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] lane
  );
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/qspi_ram_responder_if.sv
// Serial pins and SRAM macro port of the responder.
// master = host/memory side, slave = responder.
interface qspi_ram_responder_if #(
  parameter int SRAM_ADDRESS_SIZE = 9
);

  logic                         device_csb;
  logic                         device_sck;
  logic                         device_io0_read;
  logic                         device_io0_we;
  logic                         device_io1_we;
  logic                         device_io1_write;

  logic                         sram_select;
  logic                         sram_writeEnable;
  logic [3:0]                   sram_writeMask;
  logic [SRAM_ADDRESS_SIZE-1:0] sram_address;
  logic [31:0]                  sram_dataWrite;
  logic [31:0]                  sram_dataRead;

  modport master (
    output device_csb,
    output device_sck,
    output device_io0_read,
    input  device_io0_we,
    input  device_io1_we,
    input  device_io1_write,
    input  sram_select,
    input  sram_writeEnable,
    input  sram_writeMask,
    input  sram_address,
    input  sram_dataWrite,
    output sram_dataRead
  );

  modport slave (
    input  device_csb,
    input  device_sck,
    input  device_io0_read,
    output device_io0_we,
    output device_io1_we,
    output device_io1_write,
    output sram_select,
    output sram_writeEnable,
    output sram_writeMask,
    output sram_address,
    output sram_dataWrite,
    input  sram_dataRead
  );

endinterface

// File: rtl/serial_input_synchronizer.sv
// Two-flop synchronizer with an edge register for
// rise/fall detection of an oversampled serial pin.
module serial_input_synchronizer #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/qspi_ram_responder.sv
// SPI read/write responder backed by a single-port SRAM macro,
// byte addressed with auto-increment and wrap.
module qspi_ram_responder
  import qspi_ram_responder_pkg::*;
#(
  parameter int SRAM_ADDRESS_SIZE = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  qspi_ram_responder_if.slave   bus,
  output logic                  busy,
  output logic                  commandError
);

  localparam int AW = SRAM_ADDRESS_SIZE + 2;
  localparam int SW = (AW > 8) ? AW : 8;
  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [4:0] CNT_BYTE = 5'd7;
  localparam logic [4:0] CNT_ADDR = 5'(ADDRESS_SIZE - 1);

  logic csb_s, csb_rise, csb_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic io0_s, io0_rise_unused, io0_fall_unused;

  // csb sync resets low so no false fall appears after reset
  serial_input_synchronizer #(.RST_VAL(1'b0)) u_csb_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (bus.device_csb),
    .q    (csb_s),
    .rise (csb_rise),
    .fall (csb_fall)
  );

  serial_input_synchronizer #(.RST_VAL(1'b0)) u_sck_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (bus.device_sck),
    .q    (sck_level_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  serial_input_synchronizer #(.RST_VAL(1'b0)) u_io0_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (bus.device_io0_read),
    .q    (io0_s),
    .rise (io0_rise_unused),
    .fall (io0_fall_unused)
  );

  state_e                       state_q, state_d;
  logic [4:0]                   bit_cnt_q, bit_cnt_d;
  logic [SW-2:0]                shift_q, shift_d;
  logic                         is_write_q, is_write_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [31:0]                  word_q, word_d;
  logic [7:0]                   out_shift_q, out_shift_d;
  logic                         cap_q, cap_d;
  logic                         armed_q, armed_d;
  logic                         busy_q, busy_d;
  logic                         cmd_err_q, cmd_err_d;
  logic                         io1_we_q, io1_we_d;
  logic                         io1_write_q, io1_write_d;
  logic                         sel_q, sel_d;
  logic                         we_q, we_d;
  logic [3:0]                   mask_q, mask_d;
  logic [SRAM_ADDRESS_SIZE-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]                  wdata_q, wdata_d;

  logic [SW-1:0] shift_in;
  logic [AW-1:0] addr_inc;
  logic [7:0]    cur_byte;
  logic          is_rd, is_wr;

  always_comb begin
    shift_in    = {shift_q, io0_s};
    addr_inc    = addr_q + ADDR_ONE;
    cur_byte    = word_q[{addr_q[1:0], 3'b000} +: 8];
    is_rd       = (shift_in[7:0] == CMD_READ);
    is_wr       = (shift_in[7:0] == CMD_WRITE);

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    word_d      = word_q;
    out_shift_d = out_shift_q;
    io1_we_d    = io1_we_q;
    io1_write_d = io1_write_q;
    mask_d      = mask_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    sel_d       = 1'b0;
    we_d        = 1'b0;
    cmd_err_d   = 1'b0;

    // read data lands one cycle after the select pulse
    cap_d       = sel_q & ~we_q;
    if (cap_q) word_d = bus.sram_dataRead;

    armed_d     = armed_q | csb_s;
    busy_d      = armed_q & ~csb_s;

    if (csb_rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 5'd0;
      io1_we_d    = 1'b0;
      io1_write_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (csb_fall) begin
            state_d   = ST_COMMAND;
            bit_cnt_d = 5'd0;
          end
        end
        ST_COMMAND: begin
          if (sck_rise) begin
            shift_d   = shift_in[SW-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_BYTE) begin
              bit_cnt_d = 5'd0;
              unique case (1'b1)
                is_rd: begin
                  is_write_d = 1'b0;
                  state_d    = ST_ADDRESS;
                end
                is_wr: begin
                  is_write_d = 1'b1;
                  state_d    = ST_ADDRESS;
                end
                default: begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end
        ST_ADDRESS: begin
          if (sck_rise) begin
            shift_d   = shift_in[SW-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_ADDR) begin
              bit_cnt_d = 5'd0;
              addr_d    = shift_in[AW-1:0];
              if (is_write_q) begin
                state_d = ST_WRITE_DATA;
              end else begin
                state_d     = ST_READ_DATA;
                io1_we_d    = 1'b1;
                sel_d       = 1'b1;
                mask_d      = 4'b0000;
                sram_addr_d = shift_in[AW-1:2];
              end
            end
          end
        end
        ST_READ_DATA: begin
          if (sck_fall) begin
            if (bit_cnt_q == 5'd0) begin
              io1_write_d = cur_byte[7];
              out_shift_d = {cur_byte[6:0], 1'b0};
            end else begin
              io1_write_d = out_shift_q[7];
              out_shift_d = {out_shift_q[6:0], 1'b0};
            end
          end else if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_BYTE) begin
              bit_cnt_d = 5'd0;
              addr_d    = addr_inc;
              // prefetch the next word while its first bit is pending
              if (addr_q[1:0] == 2'b11) begin
                sel_d       = 1'b1;
                mask_d      = 4'b0000;
                sram_addr_d = addr_inc[AW-1:2];
              end
            end
          end
        end
        ST_WRITE_DATA: begin
          if (sck_rise) begin
            shift_d   = shift_in[SW-2:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_BYTE) begin
              bit_cnt_d   = 5'd0;
              sel_d       = 1'b1;
              we_d        = 1'b1;
              mask_d      = lane_mask(addr_q[1:0]);
              sram_addr_d = addr_q[AW-1:2];
              wdata_d     = {4{shift_in[7:0]}};
              addr_d      = addr_inc;
            end
          end
        end
        ST_IGNORE: begin
          io1_we_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      word_q      <= 32'd0;
      out_shift_q <= 8'd0;
      cap_q       <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      io1_we_q    <= 1'b0;
      io1_write_q <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      mask_q      <= 4'd0;
      sram_addr_q <= '0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      out_shift_q <= out_shift_d;
      cap_q       <= cap_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
      io1_we_q    <= io1_we_d;
      io1_write_q <= io1_write_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.device_io0_we    = 1'b0;
  assign bus.device_io1_we    = io1_we_q;
  assign bus.device_io1_write = io1_write_q;
  assign bus.sram_select      = sel_q;
  assign bus.sram_writeEnable = we_q;
  assign bus.sram_writeMask   = mask_q;
  assign bus.sram_address     = sram_addr_q;
  assign bus.sram_dataWrite   = wdata_q;
  assign busy                 = busy_q;
  assign commandError         = cmd_err_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed bench for qspi_ram_responder: SPI host driver,
// SRAM model with access log, vector table plus corner sequences.
module tb_qspi_ram_responder;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic cmd_err;

  always #5 clk = ~clk;

  qspi_ram_responder_if #(.SRAM_ADDRESS_SIZE(9)) bus ();

  qspi_ram_responder #(.SRAM_ADDRESS_SIZE(9)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .bus          (bus.slave),
    .busy         (busy),
    .commandError (cmd_err)
  );

  logic [31:0] mem [512];
  logic        mem_ready = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          oe_cnt = 0;
  logic [8:0]  wlog_a [256];
  logic [3:0]  wlog_m [256];
  logic [31:0] wlog_d [256];

  always @(posedge clk) begin
    if (bus.sram_select && !bus.sram_writeEnable)
      bus.sram_dataRead <= mem[bus.sram_address];
  end

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h03020100;
      mem[1]    <= 32'h44332211;
      mem[2]    <= 32'h88776655;
      mem[511]  <= 32'hDDCCBBAA;
      mem_ready <= 1'b1;
    end else begin
      if (bus.sram_select) begin
        if (bus.sram_writeEnable) begin
          for (int b = 0; b < 4; b++)
            if (bus.sram_writeMask[b])
              mem[bus.sram_address][8*b +: 8] <= bus.sram_dataWrite[8*b +: 8];
          wlog_a[wr_cnt[7:0]] <= bus.sram_address;
          wlog_m[wr_cnt[7:0]] <= bus.sram_writeMask;
          wlog_d[wr_cnt[7:0]] <= bus.sram_dataWrite;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (cmd_err) err_cnt <= err_cnt + 1;
      if (bus.device_io1_we) oe_cnt <= oe_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nbytes;
    logic [39:0] wdat;
    logic [39:0] exp_rd;
    int          exp_nrd;
    int          exp_nwr;
    logic [8:0]  w0a;
    logic [3:0]  w0m;
    logic [31:0] w0d;
    logic [8:0]  w1a;
    logic [3:0]  w1m;
    logic [31:0] w1d;
    logic        exp_err;
    logic        exp_oe;
  } vec_t;

  vec_t vecs [10];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    bus.device_io0_read = b;
    tick(HALF);
    bus.device_sck = 1'b1;
    m = bus.device_io1_write;
    tick(HALF);
    bus.device_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], m);
      r[i] = m;
    end
  endtask

  task automatic csb_low();
    bus.device_csb = 1'b0;
    tick(4);
  endtask

  task automatic csb_high();
    tick(HALF);
    bus.device_csb = 1'b1;
    tick(12);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rd0, wr0, er0, oe0;
    logic [7:0] r, wb, eb;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    er0 = err_cnt;
    oe0 = oe_cnt;
    csb_low();
    spi_byte(v.cmd, r);
    spi_byte(v.addr[23:16], r);
    spi_byte(v.addr[15:8], r);
    spi_byte(v.addr[7:0], r);
    for (int i = 0; i < v.nbytes; i++) begin
      wb = v.wdat[8*(v.nbytes-1-i) +: 8];
      eb = v.exp_rd[8*(v.nbytes-1-i) +: 8];
      spi_byte(wb, r);
      if (v.cmd == 8'h03)
        check($sformatf("v%0d_miso_byte%0d", idx, i), r, eb);
    end
    csb_high();
    check($sformatf("v%0d_sram_reads", idx), rd_cnt - rd0, v.exp_nrd);
    check($sformatf("v%0d_sram_writes", idx), wr_cnt - wr0, v.exp_nwr);
    check($sformatf("v%0d_cmd_error", idx), err_cnt - er0, v.exp_err);
    check($sformatf("v%0d_io1_we", idx), oe_cnt > oe0, v.exp_oe);
    if (v.exp_nwr > 0 && wr_cnt > wr0) begin
      check($sformatf("v%0d_first_wr", idx),
            {wlog_a[wr0[7:0]], wlog_m[wr0[7:0]], wlog_d[wr0[7:0]]},
            {v.w0a, v.w0m, v.w0d});
      check($sformatf("v%0d_last_wr", idx),
            {wlog_a[8'(wr_cnt-1)], wlog_m[8'(wr_cnt-1)], wlog_d[8'(wr_cnt-1)]},
            {v.w1a, v.w1m, v.w1d});
    end
    busy_check: check($sformatf("v%0d_busy_idle", idx), busy, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int wr0;
    logic [7:0] r;
    logic m;

    //          cmd    addr         n  wdat            exp_rd           nrd nwr w0a     w0m      w0d            w1a     w1m      w1d            err   oe
    vecs[0] = '{8'h03, 24'h000004, 5, 40'h0,          40'h1122334455, 2, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};
    vecs[1] = '{8'h02, 24'h000005, 2, 40'hAABB,       40'h0,          0, 2, 9'd1,   4'b0010, 32'hAAAAAAAA,  9'd1,   4'b0100, 32'hBBBBBBBB,  1'b0, 1'b0};
    vecs[2] = '{8'h03, 24'h000004, 4, 40'h0,          40'h11AABB44,   2, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};
    vecs[3] = '{8'h03, 24'h0007FF, 2, 40'h0,          40'hDD00,       2, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};
    vecs[4] = '{8'h03, 24'h001004, 1, 40'h0,          40'h11,         1, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};
    vecs[5] = '{8'h02, 24'h0007FE, 3, 40'h5AC37E,     40'h0,          0, 3, 9'd511, 4'b0100, 32'h5A5A5A5A,  9'd0,   4'b0001, 32'h7E7E7E7E,  1'b0, 1'b0};
    vecs[6] = '{8'h03, 24'h0007FE, 3, 40'h0,          40'h5AC37E,     2, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};
    vecs[7] = '{8'h9F, 24'h000000, 1, 40'h0,          40'h0,          0, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[8] = '{8'h03, 24'h000004, 1, 40'h0,          40'h11,         1, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};
    vecs[9] = '{8'h03, 24'h000010, 1, 40'h0,          40'h00,         1, 0, 9'd0,   4'b0000, 32'h0,         9'd0,   4'b0000, 32'h0,         1'b0, 1'b1};

    bus.device_csb      = 1'b1;
    bus.device_sck      = 1'b0;
    bus.device_io0_read = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_io1_we", bus.device_io1_we, 1'b0);
    check("rst_io1_write", bus.device_io1_write, 1'b0);
    check("rst_io0_we", bus.device_io0_we, 1'b0);
    check("rst_sram_ctrl",
          {bus.sram_select, bus.sram_writeEnable, bus.sram_writeMask},
          6'b0);
    check("rst_sram_addr", bus.sram_address, 9'd0);
    check("rst_sram_wdata", bus.sram_dataWrite, 32'd0);
    check("rst_busy_err", {busy, cmd_err}, 2'b00);
    rst = 1'b0;
    tick(6);
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // write aborted after 5 data bits
    wr0 = wr_cnt;
    csb_low();
    check("abort_busy_high", busy, 1'b1);
    spi_byte(8'h02, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h10, r);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    tick(HALF);
    @(negedge clk);
    bus.device_csb = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cyc = k;
      if (!busy) break;
    end
    check("abort_busy_fall_le3", cyc <= 3, 1'b1);
    tick(12);
    check("abort_no_write", wr_cnt - wr0, 0);
    run_vec(9, vecs[9]);

    // reset during READ_DATA
    csb_low();
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h04, r);
    spi_byte(8'h00, r);
    check("rstseq_byte0", r, 8'h11);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
    check("rstseq_oe_before", bus.device_io1_we, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rstseq_io1", {bus.device_io1_we, bus.device_io1_write}, 2'b00);
    check("rstseq_sram_ctrl",
          {bus.sram_select, bus.sram_writeEnable, bus.sram_writeMask},
          6'b0);
    check("rstseq_sram_addr", bus.sram_address, 9'd0);
    check("rstseq_sram_wdata", bus.sram_dataWrite, 32'd0);
    check("rstseq_busy_err", {busy, cmd_err}, 2'b00);
    bus.device_sck = 1'b0;
    bus.device_csb = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(6);
    run_vec(10, vecs[8]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
